mon_uart_dump: RTL and testbench
================================

Name: mon_uart_dump

Overview:
- Debug-dump transmitter for the FPGA monitor board. Sits downstream of the display/monitor logic and consumes the same 32-bit word selected for the 7-segment display.
- Serializes that word to the host PC as 8 uppercase ASCII hex characters, MSB nibble first, optionally followed by CR LF.
- Output is a single UART TX line: 8N1 format, fixed baud.

Parameters:
- CLKS_PER_BIT, 868: CLK100MHZ cycles per UART bit (115200 baud at 100 MHz); legal range >= 2.
- NEWLINE, 1: 1 = append 0x0D, 0x0A after the hex digits; 0 = hex digits only.

Ports:
- CLK100MHZ  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a dump; sampled every cycle, only acted on in IDLE.
- data  input  32  word to dump; captured on the accepted start edge.
- busy  output  1  high from the cycle after acceptance until the message completes.
- done  output  1  single-cycle pulse when the final stop bit ends.
- tx  output  1  UART serial line; idle high.

Behaviour:
- One clock, CLK100MHZ. Reset is synchronous and active-high.
- Reset values: tx=1, busy=0, done=0, state=IDLE, bit/char/baud counters=0.
- Reset during a frame aborts it. After the reset edge: tx=1, no done pulse, no residual characters on the next start.
- FSM states:
  - IDLE: tx=1. start=1 captures data into a shadow register, clears char_idx, goes to START. busy=1 from the next cycle.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=char[bit_idx], LSB first, CLKS_PER_BIT cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - if char_idx < NCHARS-1: char_idx++, go to START;
    - else go to IDLE, busy<=0, done<=1 for exactly one cycle.
- NCHARS = 10 if NEWLINE=1, else 8.
- Char selection:
  - char_idx 0..7 selects nibble shadow[31-4*i -: 4].
  - Nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46 (uppercase).
  - char_idx 8 = 0x0D; char_idx 9 = 0x0A.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; it is reset to 0 on each state entry, so bit boundaries are exact.
- Message length: exactly NCHARS*10*CLKS_PER_BIT cycles of busy=1. The first start-bit cycle coincides with the first busy cycle.
- start while busy=1 is ignored: not queued, shadow unchanged.
- start held high continuously: a new message is accepted in the first IDLE cycle (the done cycle). The line then shows back-to-back frames with no extra idle bits.
- Changes on data after acceptance have no effect on the message in flight.
- done and busy never both high. done is asserted in the cycle busy drops.
- Width rules: char_idx 4 bits, bit_idx 3 bits, baud counter $clog2(CLKS_PER_BIT) bits.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Basic dump:
  - Stimulus: data=0x1234ABCD, 1-cycle start pulse.
  - Required: UART decoder on tx receives 0x31,0x32,0x33,0x34,0x41,0x42,0x43,0x44,0x0D,0x0A.
  - Required: busy high exactly 400 cycles; one done pulse.
- Digit range:
  - Stimulus: data=0x0F9A5E60.
  - Required: characters "0F9A5E60" then CR LF; every start bit low and every stop bit high for 4 cycles.
- Start while busy:
  - Stimulus: start at cycle 0 with data=0x11111111; start again at cycle 50 with data=0x22222222.
  - Required: only "11111111\r\n" is transmitted; one done pulse; tx idles high after cycle 400.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle at cycle 123, then start with data=0xDEADBEEF.
  - Required: tx=1 and busy=0 the cycle after reset; no done pulse.
  - Required: the next message is exactly "DEADBEEF\r\n".
- Back-to-back:
  - Stimulus: start held high, data=0x00000000 then 0xFFFFFFFF.
  - Required: second message's start bit begins the cycle after done; "00000000\r\n" then "FFFFFFFF\r\n".
- NEWLINE=0, CLKS_PER_BIT=868:
  - Stimulus: data=0xCAFEF00D.
  - Required: 8 characters "CAFEF00D"; busy high 69440 cycles.

Source files
------------

// File: rtl/mon_uart_dump.sv
// Debug-dump UART transmitter: sends a captured 32-bit word as 8 uppercase ASCII hex
// characters, MSB nibble first, optionally followed by CR LF, on an 8N1 line.
module mon_uart_dump #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NEWLINE      = 1
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam int unsigned NCHARS = (NEWLINE != 0) ? 10 : 8;
  localparam int unsigned BW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [31:0]   shadow;
  logic [3:0]    char_idx;
  logic [2:0]    bit_idx;
  logic [BW-1:0] baud;

  logic [3:0]    nib_c;
  logic [7:0]    char_c;
  logic          baud_end_c;

  // Character currently being framed: hex digit of the selected nibble, or CR/LF.
  always_comb begin
    nib_c = 4'h0;
    case (char_idx[2:0])
      3'd0: nib_c = shadow[31:28];
      3'd1: nib_c = shadow[27:24];
      3'd2: nib_c = shadow[23:20];
      3'd3: nib_c = shadow[19:16];
      3'd4: nib_c = shadow[15:12];
      3'd5: nib_c = shadow[11:8];
      3'd6: nib_c = shadow[7:4];
      3'd7: nib_c = shadow[3:0];
      default: nib_c = 4'h0;
    endcase
    if (char_idx == 4'd8)
      char_c = 8'h0D;
    else if (char_idx == 4'd9)
      char_c = 8'h0A;
    else if (nib_c < 4'd10)
      char_c = 8'h30 + 8'(nib_c);
    else
      char_c = 8'h37 + 8'(nib_c);
  end

  assign baud_end_c = (baud == BW'(CLKS_PER_BIT - 1));

  // tx is registered and loaded on each state transition so bit edges land exactly.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state    <= IDLE;
      shadow   <= '0;
      char_idx <= '0;
      bit_idx  <= '0;
      baud     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            shadow   <= data;
            char_idx <= '0;
            bit_idx  <= '0;
            baud     <= '0;
            busy     <= 1'b1;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_end_c) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= char_c[0];
            state   <= DATA;
          end else begin
            baud <= baud + BW'(1);
          end
        end
        DATA: begin
          if (baud_end_c) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= char_c[bit_idx + 3'd1];
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        STOP: begin
          if (baud_end_c) begin
            baud <= '0;
            if (char_idx == 4'(NCHARS - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              tx    <= 1'b1;
              state <= IDLE;
            end else begin
              char_idx <= char_idx + 4'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud <= baud + BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mon_uart_dump.sv
// Bench for mon_uart_dump: cycle-exact message model, UART decoder on tx, directed and
// random scenarios at 4 clocks/bit, plus a long 868 clocks/bit instance without newline.
module tb_mon_uart_dump;

  localparam int C1    = 4;
  localparam int C2    = 868;
  localparam int FRM1  = 10 * C1;
  localparam int TOT1  = 10 * FRM1;
  localparam int FRM2  = 10 * C2;

  logic        clk = 1'b0;
  logic        reset, start, busy, done, tx;
  logic [31:0] data;
  logic        reset2, start2, busy2, done2, tx2;
  logic [31:0] data2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mon_uart_dump #(.CLKS_PER_BIT(C1), .NEWLINE(1)) dut (
    .CLK100MHZ(clk), .reset(reset), .start(start), .data(data),
    .busy(busy), .done(done), .tx(tx));

  mon_uart_dump #(.CLKS_PER_BIT(C2), .NEWLINE(0)) dut2 (
    .CLK100MHZ(clk), .reset(reset2), .start(start2), .data(data2),
    .busy(busy2), .done(done2), .tx(tx2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Message text the host must see for a given word.
  string hexs = "0123456789ABCDEF";
  function automatic logic [7:0] msg_char(input logic [31:0] w, input int i);
    if (i < 8) return hexs[(w >> (28 - 4 * i)) & 32'hF];
    return (i == 8) ? 8'h0D : 8'h0A;
  endfunction

  // Behavioural model: message position counter over a precomputed bit string.
  bit         m_busy = 1'b0;
  bit         m_done = 1'b0;
  int         m_pos  = 0;
  logic [7:0] m_chars [10];

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (!m_busy && start) begin
      for (int i = 0; i < 10; i++) m_chars[i] = msg_char(data, i);
      m_busy = 1'b1;
      m_done = 1'b0;
      m_pos  = 0;
    end else if (m_busy) begin
      m_pos++;
      m_done = 1'b0;
      if (m_pos == TOT1) begin
        m_busy = 1'b0;
        m_done = 1'b1;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  function automatic logic model_tx();
    int k, b;
    if (!m_busy) return 1'b1;
    k = m_pos / FRM1;
    b = (m_pos % FRM1) / C1;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return m_chars[k][b-1];
  endfunction

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_tx", 32'(tx), 32'(model_tx()));
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
    end
  end

  // Mid-bit sampling UART receiver plus busy/done counters on the 4 clocks/bit instance.
  logic [7:0] rx_q [$];
  bit         rx_act = 1'b0;
  int         rx_t   = 0;
  logic [9:0] rx_bits;
  int         rx_ferr  = 0;
  int         done_cnt = 0;
  int         busy_cnt = 0;

  always begin
    @(posedge clk);
    #1;
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (reset) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_t   = 0;
      end
    end else begin
      rx_t++;
      if (rx_t % C1 == C1 / 2) begin
        rx_bits[rx_t / C1] = tx;
        if (rx_t / C1 == 9) begin
          if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) rx_ferr++;
          rx_q.push_back(rx_bits[8:1]);
          rx_act = 1'b0;
        end
      end
    end
  end

  task automatic check_rx(input string name, input string s, input bit nl);
    logic [31:0] got;
    int n;
    n = s.len() + (nl ? 2 : 0);
    for (int i = 0; i < n; i++) begin
      got = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hDEAD_0000;
      check(name, got, (i < s.len()) ? 32'(s[i]) : ((i == s.len()) ? 32'h0D : 32'h0A));
    end
  endtask

  task automatic wait_done(input string name, input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (busy === 1'b0) return;
    end
    check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] d);
    start = 1'b1;
    data  = d;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic main_tests();
    int gap, len;
    logic [31:0] d;
    reset = 1'b1; start = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    // basic dump
    clear_mon();
    pulse_start(32'h1234ABCD);
    wait_done("basic", 1000);
    repeat (3) @(negedge clk);
    check_rx("basic_rx", "1234ABCD", 1'b1);
    check("basic_busy_len", 32'(busy_cnt), 32'd400);
    check("basic_done_cnt", 32'(done_cnt), 32'd1);

    // full digit range
    clear_mon();
    pulse_start(32'h0F9A5E60);
    wait_done("range", 1000);
    repeat (3) @(negedge clk);
    check_rx("range_rx", "0F9A5E60", 1'b1);
    check("range_busy_len", 32'(busy_cnt), 32'd400);

    // start while busy is ignored
    clear_mon();
    pulse_start(32'h11111111);
    repeat (49) @(negedge clk);
    pulse_start(32'h22222222);
    wait_done("ign", 1000);
    repeat (20) @(negedge clk);
    check_rx("ign_rx", "11111111", 1'b1);
    check("ign_rx_empty", 32'(rx_q.size()), 32'd0);
    check("ign_done_cnt", 32'(done_cnt), 32'd1);
    check("ign_tx_idle", 32'(tx), 32'd1);
    check("ign_busy_idle", 32'(busy), 32'd0);

    // reset mid-message
    clear_mon();
    pulse_start(32'h5A5AC3C3);
    repeat (122) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_tx", 32'(tx), 32'd1);
    check("mrst_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clk);
    check("mrst_no_done", 32'(done_cnt), 32'd0);
    clear_mon();
    pulse_start(32'hDEADBEEF);
    wait_done("mrst", 1000);
    repeat (3) @(negedge clk);
    check_rx("mrst_rx", "DEADBEEF", 1'b1);
    check("mrst_rx_empty", 32'(rx_q.size()), 32'd0);

    // back-to-back with start held high
    clear_mon();
    start = 1'b1;
    data  = 32'h00000000;
    @(negedge clk);
    data  = 32'hFFFFFFFF;
    wait_done("b2b1", 1000);
    @(negedge clk);
    check("b2b_busy_after_done", 32'(busy), 32'd1);
    check("b2b_tx_start_bit", 32'(tx), 32'd0);
    start = 1'b0;
    wait_done("b2b2", 1000);
    repeat (3) @(negedge clk);
    check_rx("b2b_rx", "00000000", 1'b1);
    check_rx("b2b_rx", "FFFFFFFF", 1'b1);
    check("b2b_busy_len", 32'(busy_cnt), 32'd800);
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // random traffic against the cycle model
    for (int it = 0; it < 25; it++) begin
      d   = $urandom;
      gap = $urandom_range(0, 4);
      len = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
      start = 1'b1;
      data  = d;
      repeat (len) @(negedge clk);
      start = 1'b0;
      data  = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(1, 300)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
      wait_idle(1000);
    end
    repeat (5) @(negedge clk);
    check("rx_framing_errors", 32'(rx_ferr), 32'd0);
  endtask

  task automatic long_test();
    int t;
    int ferr;
    logic [7:0] ch [8];
    ferr = 0;
    reset2 = 1'b1; start2 = 1'b0; data2 = '0;
    repeat (2) @(negedge clk);
    check("l_rst_tx", 32'(tx2), 32'd1);
    reset2 = 1'b0;
    start2 = 1'b1;
    data2  = 32'hCAFEF00D;
    @(negedge clk);
    start2 = 1'b0;
    data2  = 32'h0;
    t = 0;
    while (busy2 === 1'b1 && t < 80000) begin
      if ((t % FRM2) % C2 == C2 / 2 && t / FRM2 < 8) begin
        case ((t % FRM2) / C2)
          0: if (tx2 !== 1'b0) ferr++;
          9: if (tx2 !== 1'b1) ferr++;
          default: ch[t / FRM2][(t % FRM2) / C2 - 1] = tx2;
        endcase
      end
      t++;
      @(negedge clk);
    end
    check("l_busy_len", 32'(t), 32'd69440);
    check("l_done", 32'(done2), 32'd1);
    check("l_tx_idle", 32'(tx2), 32'd1);
    check("l_framing", 32'(ferr), 32'd0);
    for (int i = 0; i < 8; i++) check("l_char", 32'(ch[i]), 32'(msg_char(32'hCAFEF00D, i)));
    check("l_char0_lit", 32'(ch[0]), 32'h43);
    check("l_char3_lit", 32'(ch[3]), 32'h45);
    check("l_char7_lit", 32'(ch[7]), 32'h44);
    @(negedge clk);
    check("l_done_pulse", 32'(done2), 32'd0);
  endtask

  initial begin
    fork
      main_tests();
      long_test();
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
